pio_target_mux: RTL

Parametrised programmed-I/O target multiplexer. It sits between the PU register bus and `NUM_TGT` memory/register targets. It decodes a select field of the bus address, drives one held target strobe, and waits for that target's acknowledge. It returns a registered, `clk_div`-aligned response to the bus, with an error flag and a timeout for absent or unresponsive targets.

---
 rtl/pu_pio_pkg.sv | 20 ++
 rtl/pio_timeout_cnt.sv | 32 +++
 rtl/pio_target_mux.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pu_pio_pkg.sv
// Shared definitions for the PU programmed-I/O target path.
//   - pio_state_e : access sequencer states
//   - PIO_ERR_DATA : read data returned on any failed access
//   - PIO_SEL_LSB / PIO_SEL_W : target-select field in the PU memory map
package pu_pio_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp,
        StHold
    } pio_state_e;

    localparam logic [31:0] PIO_ERR_DATA = 32'hDEAD_BEEF;

    // Targets are decoded on 4 KiB boundaries; 16 slots in the register window.
    localparam int unsigned PIO_SEL_LSB = 12;
    localparam int unsigned PIO_SEL_W   = 4;

endpackage

// File: rtl/pio_timeout_cnt.sv
// Clearable saturating cycle counter for the target acknowledge timeout.
//   clk  : clock
//   rst  : synchronous active-high reset
//   clr  : restart the count at zero (wins over en)
//   en   : count this cycle
//   done : count has reached TIMEOUT-1
module pio_timeout_cnt #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != '1)) begin
            // Holds at all-ones so a stalled sequencer can never see done again by wrapping.
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign done = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/pio_target_mux.sv
// Programmed-I/O target multiplexer between the PU register bus and NUM_TGT targets.
// Decodes a select field of reg_addr, holds one target strobe until that target acks
// (or the timeout expires), then returns a registered response aligned to clk_div.
//   clk, rst            : clock, synchronous active-high reset
//   clk_div             : one-cycle enable marking the bus response slot
//   reg_bs/rd/wr/addr/din : bus request
//   tgt_ms/wr/addr/wdata  : latched target request, one-hot strobe
//   tgt_ack, tgt_rdata    : per-target acknowledge and read data (target i at [i*DATA_W +: DATA_W])
//   pio_ack/rvalid/rdata/err : registered bus response
module pio_target_mux
    import pu_pio_pkg::*;
#(
    parameter int unsigned        NUM_TGT  = 8,
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter int unsigned        SEL_LSB  = PIO_SEL_LSB,
    parameter int unsigned        SEL_W    = PIO_SEL_W,
    parameter int unsigned        TIMEOUT  = 255,
    parameter logic [DATA_W-1:0]  ERR_DATA = DATA_W'(PIO_ERR_DATA)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_div,
    input  logic                      reg_bs,
    input  logic                      reg_rd,
    input  logic                      reg_wr,
    input  logic [ADDR_W-1:0]         reg_addr,
    input  logic [DATA_W-1:0]         reg_din,
    output logic [NUM_TGT-1:0]        tgt_ms,
    output logic                      tgt_wr,
    output logic [ADDR_W-1:0]         tgt_addr,
    output logic [DATA_W-1:0]         tgt_wdata,
    input  logic [NUM_TGT-1:0]        tgt_ack,
    input  logic [NUM_TGT*DATA_W-1:0] tgt_rdata,
    output logic                      pio_ack,
    output logic                      pio_rvalid,
    output logic [DATA_W-1:0]         pio_rdata,
    output logic                      pio_err
);

    localparam int unsigned IDX_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

    pio_state_e        state;
    logic [IDX_W-1:0]  idx_q;
    logic              is_rd_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic [SEL_W-1:0]  sel;
    logic              sel_ok;
    logic              req;
    logic              accept;
    logic              ack_hit;
    logic [DATA_W-1:0] sel_rdata;
    logic              to_done;

    assign sel    = reg_addr[SEL_LSB +: SEL_W];
    assign sel_ok = (32'(sel) < NUM_TGT);
    assign req    = reg_bs && (reg_rd || reg_wr);
    assign accept = (state == StIdle) && req;

    // Only the latched target's ack and data matter; other targets are ignored.
    assign ack_hit   = tgt_ack[idx_q];
    assign sel_rdata = tgt_rdata[idx_q * DATA_W +: DATA_W];

    pio_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (state == StWait),
        .done (to_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            idx_q      <= '0;
            is_rd_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            tgt_ms     <= '0;
            tgt_wr     <= 1'b0;
            tgt_addr   <= '0;
            tgt_wdata  <= '0;
            pio_ack    <= 1'b0;
            pio_rvalid <= 1'b0;
            pio_rdata  <= '0;
            pio_err    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req) begin
                        idx_q     <= sel[IDX_W-1:0];
                        is_rd_q   <= reg_rd;
                        tgt_wr    <= reg_wr && !reg_rd;
                        tgt_addr  <= reg_addr;
                        tgt_wdata <= reg_din;
                        if ((reg_rd && reg_wr) || !sel_ok) begin
                            // Protocol or decode error: answer without touching any target.
                            err_q <= 1'b1;
                            state <= StResp;
                        end else begin
                            err_q  <= 1'b0;
                            tgt_ms <= NUM_TGT'(1) << sel[IDX_W-1:0];
                            state  <= StWait;
                        end
                    end
                end
                StWait: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (ack_hit) begin
                        if (is_rd_q) begin
                            rdata_q <= sel_rdata;
                        end
                        err_q  <= 1'b0;
                        tgt_ms <= '0;
                        state  <= StResp;
                    end else if (to_done) begin
                        err_q   <= 1'b1;
                        rdata_q <= ERR_DATA;
                        tgt_ms  <= '0;
                        state   <= StResp;
                    end
                end
                StResp: begin
                    if (clk_div) begin
                        pio_ack    <= 1'b1;
                        pio_rvalid <= is_rd_q;
                        pio_err    <= err_q;
                        pio_rdata  <= (err_q && is_rd_q) ? ERR_DATA : rdata_q;
                        state      <= StHold;
                    end
                end
                StHold: begin
                    // pio_rdata deliberately keeps the last response.
                    if (clk_div) begin
                        pio_ack    <= 1'b0;
                        pio_rvalid <= 1'b0;
                        pio_err    <= 1'b0;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
